// File: rtl/lock_pkg.sv
// Shared encodings for the lock controller: FSM state codes, status codes
// and the BCD check used when a new PIN is entered.
package lock_pkg;

    localparam logic [2:0] ST_LOCKED      = 3'd0;
    localparam logic [2:0] ST_UNLOCKED    = 3'd1;
    localparam logic [2:0] ST_ADJ_NEW     = 3'd2;
    localparam logic [2:0] ST_ADJ_CONFIRM = 3'd3;
    localparam logic [2:0] ST_LOCKOUT     = 3'd4;

    localparam logic [1:0] STATUS_LOCKED   = 2'b00;
    localparam logic [1:0] STATUS_UNLOCKED = 2'b01;
    localparam logic [1:0] STATUS_ADJUST   = 2'b10;
    localparam logic [1:0] STATUS_LOCKOUT  = 2'b11;

    function automatic logic is_bcd(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
               (v[7:4]   <= 4'd9) && (v[3:0]  <= 4'd9);
    endfunction

    function automatic logic [1:0] status_of(input logic [2:0] st);
        logic [1:0] s;
        case (st)
            ST_UNLOCKED:    s = STATUS_UNLOCKED;
            ST_ADJ_NEW:     s = STATUS_ADJUST;
            ST_ADJ_CONFIRM: s = STATUS_ADJUST;
            ST_LOCKOUT:     s = STATUS_LOCKOUT;
            default:        s = STATUS_LOCKED;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sec_timer.sv
// Seconds down-counter with a tick prescaler. expired is combinational so the
// owner can change state on the same edge that secs_left reaches zero.
module sec_timer #(
    parameter int TICKS_PER_SEC = 500,
    parameter int SEC_W         = 8
) (
    input  logic             clk_500Hz,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    output logic [SEC_W-1:0] secs_left,
    output logic             expired
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0]    r_presc;
    logic [SEC_W-1:0] r_secs;

    always_ff @(posedge clk_500Hz) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_secs  <= '0;
        end else if (load) begin
            r_presc <= PRESC_RELOAD;
            r_secs  <= load_val;
        end else if (r_secs != '0) begin
            if (r_presc == '0) begin
                r_presc <= PRESC_RELOAD;
                r_secs  <= r_secs - 1'b1;
            end else begin
                r_presc <= r_presc - 1'b1;
            end
        end
    end

    assign secs_left = r_secs;
    // High during the last cycle of the final second, i.e. the cycle whose edge zeroes secs_left.
    assign expired   = (r_secs == SEC_W'(1)) && (r_presc == '0);

endmodule

// File: rtl/lock_controller.sv
// Lock state owner: PIN compare, failed-attempt lockout, idle relock and PIN change.
// state          | meaning
// ST_LOCKED      | waiting for a PIN, counting wrong attempts
// ST_UNLOCKED    | open; relocks on btn_lock or idle timeout
// ST_ADJ_NEW     | waiting for the new PIN (BCD only)
// ST_ADJ_CONFIRM | waiting for the new PIN a second time
// ST_LOCKOUT     | alarm; all input ignored until the lockout timer expires
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PIN   = 16'h1234,
    parameter int          MAX_FAILS     = 3,
    parameter int          TICKS_PER_SEC = 500,
    parameter int          LOCKOUT_SECS  = 30,
    parameter int          IDLE_SECS     = 10
) (
    input  logic        clk_500Hz,
    input  logic        rst_n,
    input  logic [15:0] userPin,
    input  logic        validPin,
    input  logic        btn_lock,
    input  logic        btn_adjust,
    output logic [1:0]  status,
    output logic        unlocked_led,
    output logic        alarm,
    output logic [1:0]  fail_count,
    output logic [7:0]  secs_left,
    output logic        pin_changed,
    output logic        adj_err
);

    logic [2:0]  r_state;
    logic [15:0] r_pin;
    logic [15:0] r_cand;
    logic [1:0]  r_fail;
    logic        r_lock_q;
    logic        r_adj_q;
    logic [1:0]  r_status;
    logic        r_led;
    logic        r_alarm;
    logic        r_pin_changed;
    logic        r_adj_err;

    logic        w_lock_edge;
    logic        w_adj_edge;
    logic        w_expired;
    logic        w_load;
    logic [7:0]  w_load_val;
    logic        w_adj_valid;
    logic [2:0]  w_next_state;
    logic [15:0] w_next_pin;
    logic [15:0] w_next_cand;
    logic [1:0]  w_next_fail;
    logic [1:0]  w_fail_inc;
    logic        w_pin_changed;
    logic        w_adj_err;

    assign w_lock_edge = btn_lock & ~r_lock_q;
    assign w_adj_edge  = btn_adjust & ~r_adj_q;
    assign w_fail_inc  = r_fail + 2'd1;

    always_comb begin
        w_next_state  = r_state;
        w_next_pin    = r_pin;
        w_next_cand   = r_cand;
        w_next_fail   = r_fail;
        w_pin_changed = 1'b0;
        w_adj_err     = 1'b0;
        w_adj_valid   = 1'b0;
        case (r_state)
            ST_LOCKED: begin
                if (validPin) begin
                    if (userPin == r_pin) begin
                        w_next_state = ST_UNLOCKED;
                        w_next_fail  = 2'd0;
                    end else if (w_fail_inc == 2'(MAX_FAILS)) begin
                        w_next_state = ST_LOCKOUT;
                        w_next_fail  = 2'd0;
                    end else begin
                        w_next_fail  = w_fail_inc;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (w_lock_edge)      w_next_state = ST_LOCKED;
                else if (w_adj_edge)  w_next_state = ST_ADJ_NEW;
                else if (w_expired)   w_next_state = ST_LOCKED;
            end
            ST_ADJ_NEW: begin
                if (w_lock_edge) begin
                    w_next_state = ST_LOCKED;
                end else if (validPin) begin
                    w_adj_valid = 1'b1;
                    if (is_bcd(userPin)) begin
                        w_next_cand  = userPin;
                        w_next_state = ST_ADJ_CONFIRM;
                    end else begin
                        w_adj_err = 1'b1;
                    end
                end else if (w_expired) begin
                    w_next_state = ST_LOCKED;
                end
            end
            ST_ADJ_CONFIRM: begin
                if (w_lock_edge) begin
                    w_next_state = ST_LOCKED;
                end else if (validPin) begin
                    w_adj_valid = 1'b1;
                    if (userPin == r_cand) begin
                        w_next_pin    = r_cand;
                        w_pin_changed = 1'b1;
                        w_next_state  = ST_LOCKED;
                    end else begin
                        w_adj_err    = 1'b1;
                        w_next_state = ST_ADJ_NEW;
                    end
                end else if (w_expired) begin
                    w_next_state = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (w_expired) w_next_state = ST_LOCKED;
            end
            default: w_next_state = ST_LOCKED;
        endcase
    end

    // Any state change or accepted ADJ entry restarts the shared timer; LOCKED loads 0.
    assign w_load = (w_next_state != r_state) | w_adj_valid;

    always_comb begin
        case (w_next_state)
            ST_UNLOCKED, ST_ADJ_NEW, ST_ADJ_CONFIRM: w_load_val = 8'(IDLE_SECS);
            ST_LOCKOUT:                              w_load_val = 8'(LOCKOUT_SECS);
            default:                                 w_load_val = 8'd0;
        endcase
    end

    sec_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .SEC_W        (8)
    ) u_sec_timer (
        .clk_500Hz(clk_500Hz),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .secs_left(secs_left),
        .expired  (w_expired)
    );

    always_ff @(posedge clk_500Hz) begin
        if (!rst_n) begin
            r_state       <= ST_LOCKED;
            r_pin         <= DEFAULT_PIN;
            r_cand        <= 16'h0000;
            r_fail        <= 2'd0;
            r_lock_q      <= 1'b0;
            r_adj_q       <= 1'b0;
            r_status      <= STATUS_LOCKED;
            r_led         <= 1'b0;
            r_alarm       <= 1'b0;
            r_pin_changed <= 1'b0;
            r_adj_err     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_pin         <= w_next_pin;
            r_cand        <= w_next_cand;
            r_fail        <= w_next_fail;
            r_lock_q      <= btn_lock;
            r_adj_q       <= btn_adjust;
            r_status      <= status_of(w_next_state);
            r_led         <= (w_next_state == ST_UNLOCKED);
            r_alarm       <= (w_next_state == ST_LOCKOUT);
            r_pin_changed <= w_pin_changed;
            r_adj_err     <= w_adj_err;
        end
    end

    assign status       = r_status;
    assign unlocked_led = r_led;
    assign alarm        = r_alarm;
    assign fail_count   = r_fail;
    assign pin_changed  = r_pin_changed;
    assign adj_err      = r_adj_err;

endmodule
